// File: rtl/dla_common_pkg.sv
// Shared helpers for the DLA stream blocks.
//   divCeil : integer ceiling division, usable in constant expressions.
package dla_common_pkg;

    function automatic int unsigned divCeil(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/dla_mux_pkg.sv
// Types shared by dla_mux and its bench-facing users.
//   mux_sel_config_t : job descriptor, assembled from config words LSB word first.
//   mux_state_t      : job FSM states.
package dla_mux_pkg;

    // num_beats occupies the upper word, select the lower; only select[0] is meaningful.
    typedef struct packed {
        logic [31:0] num_beats;
        logic [31:0] select;
    } mux_sel_config_t;

    typedef enum logic [1:0] {
        CONFIG,
        STREAM,
        DONE
    } mux_state_t;

    localparam int unsigned CFG_BITS = $bits(mux_sel_config_t);

endpackage

// File: rtl/dla_st_pipeline_stage.sv
// One-deep registered valid/ready stage with full throughput.
// Ports:
//   clk      : clock
//   i_resetn : synchronous active-low reset, empties the stage
//   i_valid / i_data / o_ready : upstream handshake
//   o_valid / o_data / i_ready : downstream handshake
module dla_st_pipeline_stage #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  i_resetn,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;

    // The slot frees up in the same cycle it drains, giving 1 beat/cycle.
    assign o_ready = !valid_q || i_ready;
    assign o_valid = valid_q;
    assign o_data  = data_q;

    always_ff @(posedge clk) begin
        if (!i_resetn) begin
            valid_q <= 1'b0;
        end else if (o_ready) begin
            valid_q <= i_valid;
        end
    end

    // Payload only moves on a load, so it stays stable while stalled.
    always_ff @(posedge clk) begin
        if (o_ready && i_valid) begin
            data_q <= i_data;
        end
    end

endmodule

// File: rtl/dla_mux.sv
// 2:1 stream merge: each configured job forwards num_beats beats from the
// selected input (select=0 -> input 1, select=1 -> input 2) through one
// registered stage, pulses o_done, then waits for the next config.
// Ports:
//   clk_dla, i_sclr                           : clock, synchronous active-high reset
//   i_config_data/valid, o_config_ready       : config word channel
//   i_1_valid/data, o_1_ready                 : input 1
//   i_2_valid/data, o_2_ready                 : input 2
//   o_valid/data, i_ready                     : merged output
//   o_done                                    : one-cycle job-complete pulse
module dla_mux
    import dla_common_pkg::*;
    import dla_mux_pkg::*;
#(
    parameter int unsigned CONFIG_WIDTH = 32,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                    clk_dla,
    input  logic                    i_sclr,
    input  logic [CONFIG_WIDTH-1:0] i_config_data,
    input  logic                    i_config_valid,
    output logic                    o_config_ready,
    input  logic                    i_1_valid,
    input  logic [DATA_WIDTH-1:0]   i_1_data,
    output logic                    o_1_ready,
    input  logic                    i_2_valid,
    input  logic [DATA_WIDTH-1:0]   i_2_data,
    output logic                    o_2_ready,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_data,
    input  logic                    i_ready,
    output logic                    o_done
);

    localparam int unsigned NUM_WORDS = divCeil(CFG_BITS, CONFIG_WIDTH);
    localparam int unsigned OFFSET_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [OFFSET_W-1:0] LAST_OFFSET = OFFSET_W'(NUM_WORDS - 1);

    if ((CFG_BITS % CONFIG_WIDTH) != 0) begin : g_cfg_width_check
        $error("dla_mux: config struct width must be a multiple of CONFIG_WIDTH");
    end

    mux_state_t            state_q;
    mux_sel_config_t       cfg_q;
    mux_sel_config_t       cfg_next;
    logic [OFFSET_W-1:0]   offset_q;
    logic [31:0]           in_rem_q;
    logic [31:0]           out_rem_q;

    logic                  cfg_fire;
    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  in_open;
    logic                  stage_in_valid;
    logic                  stage_ready;
    logic                  stage_in_ready;
    logic                  in_fire;
    logic                  out_fire;

    assign o_config_ready = (state_q == CONFIG);
    assign o_done         = (state_q == DONE);
    assign cfg_fire       = i_config_valid && o_config_ready;

    // New words enter at the top so the first word ends up in the low bits.
    assign cfg_next = mux_sel_config_t'((CFG_BITS'(i_config_data) << (CFG_BITS - CONFIG_WIDTH))
                                        | (cfg_q >> CONFIG_WIDTH));

    assign sel_valid = cfg_q.select[0] ? i_2_valid : i_1_valid;
    assign sel_data  = cfg_q.select[0] ? i_2_data  : i_1_data;

    // Stop pulling once num_beats are taken so surplus beats wait for the next job.
    assign in_open        = (state_q == STREAM) && (in_rem_q != 32'd0);
    assign stage_in_valid = sel_valid && in_open;
    assign stage_in_ready = stage_ready && in_open;
    assign o_1_ready      = stage_in_ready && !cfg_q.select[0];
    assign o_2_ready      = stage_in_ready && cfg_q.select[0];
    assign in_fire        = stage_in_valid && stage_ready;
    assign out_fire       = o_valid && i_ready;

    always_ff @(posedge clk_dla) begin
        if (i_sclr) begin
            state_q   <= CONFIG;
            cfg_q     <= '0;
            offset_q  <= '0;
            in_rem_q  <= '0;
            out_rem_q <= '0;
        end else begin
            unique case (state_q)
                CONFIG: begin
                    if (cfg_fire) begin
                        cfg_q <= cfg_next;
                        if (offset_q == LAST_OFFSET) begin
                            offset_q  <= '0;
                            in_rem_q  <= cfg_next.num_beats;
                            out_rem_q <= cfg_next.num_beats;
                            state_q   <= (cfg_next.num_beats == 32'd0) ? DONE : STREAM;
                        end else begin
                            offset_q <= offset_q + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (in_fire) begin
                        in_rem_q <= in_rem_q - 32'd1;
                    end
                    if (out_fire) begin
                        out_rem_q <= out_rem_q - 32'd1;
                        if (out_rem_q == 32'd1) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= CONFIG;
                end
                default: begin
                    state_q <= CONFIG;
                end
            endcase
        end
    end

    dla_st_pipeline_stage #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
        .clk     (clk_dla),
        .i_resetn(~i_sclr),
        .i_valid (stage_in_valid),
        .i_data  (sel_data),
        .o_ready (stage_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready)
    );

endmodule

// File: tb/tb_dla_mux.sv
// Bench for dla_mux: a transaction-level model (job phase, beat counts, a
// one-slot queue for the output stage) is checked against the DUT on every
// negedge, plus literal expectations on the emitted beat sequences.
module tb_dla_mux;

    localparam int unsigned CW = 32;
    localparam int unsigned DW = 32;

    logic          clk_dla = 1'b0;
    logic          i_sclr;
    logic [CW-1:0] i_config_data;
    logic          i_config_valid;
    logic          o_config_ready;
    logic          i_1_valid;
    logic [DW-1:0] i_1_data;
    logic          o_1_ready;
    logic          i_2_valid;
    logic [DW-1:0] i_2_data;
    logic          o_2_ready;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          i_ready;
    logic          o_done;

    always #5 clk_dla = ~clk_dla;

    dla_mux #(
        .CONFIG_WIDTH(CW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk_dla       (clk_dla),
        .i_sclr        (i_sclr),
        .i_config_data (i_config_data),
        .i_config_valid(i_config_valid),
        .o_config_ready(o_config_ready),
        .i_1_valid     (i_1_valid),
        .i_1_data      (i_1_data),
        .o_1_ready     (o_1_ready),
        .i_2_valid     (i_2_valid),
        .i_2_data      (i_2_data),
        .o_2_ready     (o_2_ready),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .i_ready       (i_ready),
        .o_done        (o_done)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Upstream sources and downstream ready pattern (0: always, 1: toggle, 2: held low).
    logic [DW-1:0] src1[$];
    logic [DW-1:0] src2[$];
    int            rdy_mode = 0;

    // Observed output beats and done pulses.
    logic [DW-1:0] got[$];
    int            done_cnt = 0;

    // Model: phase 0 = waiting for config, 1 = streaming, 2 = done cycle.
    bit              m_live = 0;
    int              m_phase = 0;
    logic [CW-1:0]   m_words[$];
    bit              m_sel = 0;
    longint unsigned m_n = 0;
    longint unsigned m_in = 0;
    longint unsigned m_out = 0;
    logic [DW-1:0]   m_stage[$];

    always @(negedge clk_dla) begin : compare
        bit e_valid;
        bit take;
        if (m_live && o_valid && i_ready) got.push_back(o_data);
        if (m_live && o_done) done_cnt++;
        e_valid = (m_stage.size() != 0);
        take    = (m_phase == 1) && (m_in < m_n) && (!e_valid || i_ready);
        if (m_live) begin
            chk("o_config_ready", o_config_ready, m_phase == 0);
            chk("o_done", o_done, m_phase == 2);
            chk("o_valid", o_valid, e_valid);
            chk("o_1_ready", o_1_ready, take && !m_sel);
            chk("o_2_ready", o_2_ready, take && m_sel);
            if (e_valid) chk("o_data", o_data, m_stage[0]);
        end
        if (i_sclr) begin
            m_live  = 1;
            m_phase = 0;
            m_sel   = 0;
            m_n     = 0;
            m_in    = 0;
            m_out   = 0;
            m_words.delete();
            m_stage.delete();
        end else if (m_live) begin
            case (m_phase)
                0: begin
                    if (i_config_valid) begin
                        m_words.push_back(i_config_data);
                        if (m_words.size() == 2) begin
                            m_sel   = m_words[0][0];
                            m_n     = m_words[1];
                            m_in    = 0;
                            m_out   = 0;
                            m_words.delete();
                            m_phase = (m_n == 0) ? 2 : 1;
                        end
                    end
                end
                1: begin
                    if (e_valid && i_ready) begin
                        void'(m_stage.pop_front());
                        m_out++;
                        if (m_out == m_n) m_phase = 2;
                    end
                    if (take && (m_sel ? i_2_valid : i_1_valid)) begin
                        m_stage.push_back(m_sel ? i_2_data : i_1_data);
                        m_in++;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Source/sink driver: pop a source on a completed handshake, present the next beat.
    initial begin : driver
        bit f1;
        bit f2;
        forever begin
            @(negedge clk_dla);
            f1 = i_1_valid && o_1_ready;
            f2 = i_2_valid && o_2_ready;
            @(posedge clk_dla);
            #1;
            if (f1 && src1.size() > 0) void'(src1.pop_front());
            if (f2 && src2.size() > 0) void'(src2.pop_front());
            i_1_valid = (src1.size() > 0);
            i_1_data  = (src1.size() > 0) ? src1[0] : '0;
            i_2_valid = (src2.size() > 0);
            i_2_data  = (src2.size() > 0) ? src2[0] : '0;
            case (rdy_mode)
                0:       i_ready = 1'b1;
                1:       i_ready = ~i_ready;
                default: i_ready = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk_dla);
        #1;
    endtask

    task automatic send_word(input logic [CW-1:0] w);
        bit acc = 0;
        i_config_valid = 1'b1;
        i_config_data  = w;
        for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clk_dla);
            acc = o_config_ready;
            tick();
        end
        i_config_valid = 1'b0;
        chk("config_accept", acc, 1);
    endtask

    task automatic send_cfg(input bit sel, input logic [31:0] n);
        send_word({31'h5a5a_5a5a, sel});
        send_word(n);
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 400 && done_cnt < target; k++) tick();
        chk("done_reached", done_cnt, target);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int d0;
        i_sclr         = 1'b1;
        i_config_valid = 1'b1;
        i_config_data  = 32'h1;
        i_1_valid      = 1'b0;
        i_1_data       = '0;
        i_2_valid      = 1'b0;
        i_2_data       = '0;
        i_ready        = 1'b1;

        // Reset with valids asserted everywhere.
        src1.push_back(32'h11);
        src2.push_back(32'h22);
        repeat (3) tick();
        i_sclr         = 1'b0;
        i_config_valid = 1'b0;
        src1.delete();
        src2.delete();
        @(negedge clk_dla);
        chk("rst_config_ready", o_config_ready, 1);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_1_ready", o_1_ready, 0);
        chk("rst_o_2_ready", o_2_ready, 0);
        chk("rst_o_done", o_done, 0);
        tick();

        // Job {sel=0, n=4} with a fifth beat that must stay stalled.
        got.delete();
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) src1.push_back(32'hA0 + i);
        send_cfg(1'b0, 32'd4);
        wait_done(d0 + 1);
        repeat (4) tick();
        chk("t2_beats", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("t2_beat", got[i], 32'hA0 + i);
        chk("t2_stalled_left", src1.size(), 1);
        chk("t2_single_done", done_cnt, d0 + 1);
        src1.delete();
        tick();

        // Job {sel=1, n=3} with toggling downstream ready.
        got.delete();
        d0 = done_cnt;
        rdy_mode = 1;
        for (int i = 0; i < 3; i++) src2.push_back(32'hB0 + i);
        send_cfg(1'b1, 32'd3);
        wait_done(d0 + 1);
        repeat (4) tick();
        chk("t3_beats", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk("t3_beat", got[i], 32'hB0 + i);
        chk("t3_single_done", done_cnt, d0 + 1);
        rdy_mode = 0;
        tick();

        // Job {sel=0, n=0}: straight to done, then config again.
        got.delete();
        d0 = done_cnt;
        send_cfg(1'b0, 32'd0);
        wait_done(d0 + 1);
        @(negedge clk_dla);
        chk("t4_config_ready_after", o_config_ready, 1);
        tick();
        chk("t4_no_beats", got.size(), 0);

        // Reset mid-job with a beat held in the stage.
        got.delete();
        for (int i = 0; i < 5; i++) src1.push_back(32'hC0 + i);
        send_cfg(1'b0, 32'd5);
        for (int k = 0; k < 100 && got.size() < 2; k++) tick();
        rdy_mode = 2;
        repeat (3) tick();
        @(negedge clk_dla);
        chk("t5_held_valid", o_valid, 1);
        tick();
        d0 = done_cnt;
        i_sclr = 1'b1;
        tick();
        i_sclr = 1'b0;
        src1.delete();
        rdy_mode = 0;
        @(negedge clk_dla);
        chk("t5_flushed_valid", o_valid, 0);
        chk("t5_no_done", o_done, 0);
        tick();
        chk("t5_done_count", done_cnt, d0);
        got.delete();
        src2.push_back(32'hD0);
        send_cfg(1'b1, 32'd1);
        wait_done(d0 + 1);
        tick();
        chk("t5_after_beats", got.size(), 1);
        if (got.size() > 0) chk("t5_after_beat", got[0], 32'hD0);

        // Back-to-back jobs with the second config presented early.
        got.delete();
        d0 = done_cnt;
        src1.push_back(32'hE0);
        src1.push_back(32'hE1);
        src2.push_back(32'hF0);
        src2.push_back(32'hF1);
        send_cfg(1'b0, 32'd2);
        send_cfg(1'b1, 32'd2);
        wait_done(d0 + 2);
        repeat (3) tick();
        chk("t6_beats", got.size(), 4);
        if (got.size() == 4) begin
            chk("t6_beat0", got[0], 32'hE0);
            chk("t6_beat1", got[1], 32'hE1);
            chk("t6_beat2", got[2], 32'hF0);
            chk("t6_beat3", got[3], 32'hF1);
        end
        chk("t6_two_dones", done_cnt, d0 + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dla_mux.md
Name: dla_mux

Overview:
- 2:1 stream merge that sits directly downstream of the two DLA demux outputs and recombines them onto one output stream.
- Each job is configured over the config channel with a select bit and a beat count.
- Forwards exactly that many beats from the selected input through a one-deep registered stage, pulses o_done, then returns to waiting for the next config.
- Unselected input is back-pressured for the whole job.

Parameters:
- CONFIG_WIDTH, 32: width of a config word. $bits(mux_sel_config_t) must be an exact multiple of it; elaboration-time assert.
- DATA_WIDTH, 32: payload width of both inputs and the output.

Ports:
- clk_dla  in  1  sole clock
- i_sclr  in  1  synchronous reset, active-high; sampled on posedge clk_dla
- i_config_data  in  CONFIG_WIDTH  config word
- i_config_valid  in  1  config word valid
- o_config_ready  out  1  high only in CONFIG state
- i_1_valid  in  1  input 1 valid (select=0)
- i_1_data  in  DATA_WIDTH  input 1 payload
- o_1_ready  out  1  backpressure to input 1
- i_2_valid  in  1  input 2 valid (select=1)
- i_2_data  in  DATA_WIDTH  input 2 payload
- o_2_ready  out  1  backpressure to input 2
- o_valid  out  1  output valid
- o_data  out  DATA_WIDTH  output payload
- i_ready  in  1  backpressure from downstream
- o_done  out  1  one-cycle pulse: job complete

Behaviour:
- Reset (i_sclr=1 at clock edge):
  - state=CONFIG, config_offset=0, both counters=0, cfg.select=0, pipeline stage emptied.
  - Outputs during/after reset: o_config_ready=1 (first cycle after reset), o_1_ready=o_2_ready=0, o_valid=0, o_done=0.
  - Reset mid-job discards any in-flight beat with no o_done.
  - i_sclr has priority over every other event in the same cycle.
- Config format, mux_sel_config_t, 2 words at CONFIG_WIDTH=32:
  - word0 -> bits[31:0], select = bit0 (bits 31:1 ignored).
  - word1 -> bits[63:32], num_beats (unsigned 32-bit).
  - Words are assembled LSB word first: each accepted word shifts in at the top, cfg = (word << ($bits(cfg)-CONFIG_WIDTH)) | (cfg >> CONFIG_WIDTH).
- State CONFIG:
  - Accept a word when i_config_valid & o_config_ready; config_offset increments per word.
  - On the last word: offset -> 0; in_remaining and out_remaining are loaded from the incoming num_beats; state -> STREAM, or -> DONE if num_beats==0.
- State STREAM:
  - sel_valid/sel_data come from input 1 if select==0, else input 2.
  - Stage input ready = stage_ready & (in_remaining!=0). The selected o_x_ready gets this value; the other o_x_ready=0.
  - An input beat is accepted when the selected valid & ready; in_remaining decrements.
  - An output beat completes on o_valid & i_ready; out_remaining decrements.
  - When an output beat completes with out_remaining==1: state -> DONE.
  - Input acceptance stops at num_beats, so extra upstream beats remain stalled for the next job.
- State DONE: o_done=1 for exactly this one cycle, then -> CONFIG. The config channel cannot be accepted in the DONE cycle.
- Pipeline stage:
  - One registered stage; latency input-accept -> o_valid is 1 cycle.
  - Sustains 1 beat/cycle at full throughput.
  - o_data is held stable while o_valid & ~i_ready.
- Counters are 32-bit. num_beats=0xFFFFFFFF is legal and must not wrap.
- Input valids are ignored outside STREAM; both readys are 0 there.

Decomposition:
- Shared package: dla_mux_pkg holds typedef mux_sel_config_t (packed: num_beats[31:0], select[31:0]) and a state enum {CONFIG, STREAM, DONE}.
- Use divCeil from dla_common_pkg.
- Sub-module: dla_st_pipeline_stage for the registered output stage, with its i_resetn driven by ~i_sclr.
- No reset synchronizer; reset is already synchronous.

Test Plan:
- Reset with i_config_valid=1 and input valids=1 -> o_config_ready=1 after release; o_valid=0, o_1_ready=o_2_ready=0, o_done=0.
- Config {sel=0, n=4}, input 1 streams 0xA0..0xA3, i_ready=1 -> o_data A0..A3 on 4 consecutive cycles starting 1 cycle after first accept; o_2_ready stays 0; o_done pulses 1 cycle after A3 leaves; 5th input-1 beat stalls.
- Config {sel=1, n=3}, i_ready toggling 1/0 -> input 2 data 0xB0..0xB2 emerges in order, each held stable while i_ready=0; exactly 3 beats out; single o_done.
- Config {sel=0, n=0} -> o_done the cycle after word1 is accepted; no ready asserted; o_config_ready=1 the following cycle.
- Assert i_sclr after 2 of 5 beats with one beat held in the stage (i_ready=0) -> o_valid=0 next cycle; no o_done; new config {sel=1, n=1} completes normally.
- Back-to-back jobs {sel=0, n=2} then {sel=1, n=2} with config words presented early -> config words are accepted only in CONFIG; output order is input-1 pair then input-2 pair; two o_done pulses.
